// File: rtl/i2c_wr_seq.sv
// Write-transaction sequencer feeding the I2C byte sender: buffers payload bytes
// in a FIFO and hands them out one at a time, with a per-byte timeout.
module i2c_wr_seq #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [6:0]                  cmd_dev_addr,
  input  logic [LEN_W-1:0]            cmd_len,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [7:0]                  wr_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        pre_ready,
  output logic [7:0]                  pre_data,
  input  logic                        byte_done,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_FETCH, S_DONE, S_ERR
  } state_t;

  state_t            state, next_state;
  logic [6:0]        addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [TW-1:0]     timer_q;
  logic              byte_done_q;
  logic              bd_rise;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              fifo_empty;
  logic              push, pop;
  logic              load_cmd, timer_clr, timer_inc, rem_dec, flush;
  logic              pre_ready_d, done_d, err_d, busy_d;
  logic [7:0]        pre_data_d;
  logic              timer_exp;

  assign bd_rise    = byte_done & ~byte_done_q;
  assign fifo_empty = (fifo_level == LW'(0));
  assign wr_ready   = (fifo_level != LW'(FIFO_DEPTH));
  assign push       = wr_valid & wr_ready;
  assign cmd_ready  = (state == S_IDLE);
  assign timer_exp  = (timer_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a byte_done rise beats a same-cycle timeout
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (cmd_valid) next_state = S_ADDR;
      S_ADDR:  next_state = S_WAIT;
      S_WAIT: begin
        if (bd_rise)        next_state = (rem_q == LEN_W'(0)) ? S_DONE : S_FETCH;
        else if (timer_exp) next_state = S_ERR;
      end
      S_FETCH: begin
        if (!fifo_empty)    next_state = S_WAIT;
        else if (timer_exp) next_state = S_ERR;
      end
      S_DONE:  next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    load_cmd    = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    rem_dec     = 1'b0;
    flush       = 1'b0;
    pop         = 1'b0;
    pre_ready_d = 1'b0;
    pre_data_d  = pre_data;
    case (state)
      S_IDLE: load_cmd = cmd_valid;
      S_ADDR: begin
        pre_ready_d = 1'b1;
        pre_data_d  = {addr_q, 1'b0};
        timer_clr   = 1'b1;
      end
      S_WAIT: begin
        if (next_state == S_FETCH) timer_clr = 1'b1;
        else                       timer_inc = 1'b1;
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          pre_ready_d = 1'b1;
          pre_data_d  = mem[rptr];
          rem_dec     = 1'b1;
          timer_clr   = 1'b1;
        end else begin
          timer_inc   = 1'b1;
        end
      end
      S_ERR:   flush = 1'b1;
      default: ;
    endcase
    done_d = (next_state == S_DONE);
    err_d  = (next_state == S_ERR);
    busy_d = (next_state != S_IDLE);
  end

  // Registered outputs, command context, timer and edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_ready   <= 1'b0;
      pre_data    <= 8'hFF;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      addr_q      <= 7'd0;
      rem_q       <= '0;
      timer_q     <= '0;
      byte_done_q <= 1'b1;
    end else begin
      pre_ready   <= pre_ready_d;
      pre_data    <= pre_data_d;
      done        <= done_d;
      err         <= err_d;
      busy        <= busy_d;
      byte_done_q <= byte_done;
      if (load_cmd) begin
        addr_q <= cmd_dev_addr;
        rem_q  <= cmd_len;
      end else if (rem_dec) begin
        rem_q  <= rem_q - LEN_W'(1);
      end
      if (timer_clr)      timer_q <= '0;
      else if (timer_inc) timer_q <= timer_q + TW'(1);
    end
  end

  // FIFO pointers and occupancy; an error flush overrides any push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: tb/tb_i2c_wr_seq.sv
// Self-checking bench for i2c_wr_seq: emulates the byte sender and keeps a
// queue model of the payload FIFO to predict every presented byte.
module tb_i2c_wr_seq;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LEN_W = 5;
  localparam int unsigned TO    = 1023;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [6:0]       cmd_dev_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;
  logic [LVL_W-1:0] fifo_level;
  logic             pre_ready;
  logic [7:0]       pre_data;
  logic             byte_done;
  logic             busy;
  logic             done;
  logic             err;

  int passed = 0;
  int total  = 0;
  logic [7:0] model_q[$];

  i2c_wr_seq #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .fifo_level(fifo_level),
    .pre_ready(pre_ready), .pre_data(pre_data), .byte_done(byte_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    cmd_valid = 1'b0; cmd_dev_addr = 7'd0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = 8'd0; byte_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic exp_rdy;
    exp_rdy = (model_q.size() < DEPTH);
    total++;
    if (wr_ready !== exp_rdy) $display("FAIL wr_ready: got %b want %b", wr_ready, exp_rdy);
    else passed++;
    wr_valid = 1'b1; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
    if (exp_rdy) model_q.push_back(d);
  endtask

  task automatic issue_cmd(input logic [6:0] a, input int len);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    else passed++;
    cmd_valid = 1'b1; cmd_dev_addr = a; cmd_len = LEN_W'(len);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_dev_addr = 7'($urandom); cmd_len = LEN_W'($urandom);
    total++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || pre_ready !== 1'b0)
      $display("FAIL addr_cycle: busy=%b cmd_ready=%b pre_ready=%b want 1 0 0", busy, cmd_ready, pre_ready);
    else passed++;
  endtask

  // One full transaction with the sender acking each byte after dly cycles (dly<0: random)
  task automatic run_txn(input logic [6:0] a, input int len, input int dly);
    logic [7:0] exp_q[$];
    bit under;
    bit stable;
    int d;
    int at;
    under = (len > model_q.size());
    exp_q.push_back({a, 1'b0});
    for (int i = 0; i < len && model_q.size() > 0; i++) exp_q.push_back(model_q.pop_front());
    issue_cmd(a, len);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      total++;
      if (pre_ready !== 1'b1 || pre_data !== exp_q[i])
        $display("FAIL byte%0d: pre_ready=%b pre_data=%h want 1 %h", i, pre_ready, pre_data, exp_q[i]);
      else passed++;
      d = (dly < 0) ? int'($urandom_range(12, 3)) : dly;
      stable = 1'b1;
      repeat (d) begin
        @(negedge clk);
        if (pre_ready !== 1'b0 || pre_data !== exp_q[i] || done !== 1'b0 || err !== 1'b0) stable = 1'b0;
      end
      total++;
      if (!stable) $display("FAIL hold%0d: outputs changed before byte_done, want pre_data %h held", i, exp_q[i]);
      else passed++;
      byte_done = 1'b1;
      @(negedge clk);
      byte_done = 1'b0;
    end
    if (!under) begin
      total++;
      if (done !== 1'b1 || pre_ready !== 1'b0 || err !== 1'b0)
        $display("FAIL done_pulse: done=%b pre_ready=%b err=%b want 1 0 0", done, pre_ready, err);
      else passed++;
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || fifo_level !== LVL_W'(model_q.size()))
        $display("FAIL after_done: done=%b busy=%b cmd_ready=%b level=%0d want 0 0 1 %0d",
                 done, busy, cmd_ready, fifo_level, model_q.size());
      else passed++;
    end else begin
      at = 0;
      for (int k = 1; k <= int'(TO) + 8; k++) begin
        if (k > 1) @(negedge clk);
        if (err === 1'b1) begin at = k; break; end
      end
      total++;
      if (at != int'(TO) + 1) $display("FAIL underrun_err_time: got %0d want %0d", at, TO + 1);
      else passed++;
      @(negedge clk);
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || fifo_level !== LVL_W'(0) || cmd_ready !== 1'b1)
        $display("FAIL after_err: err=%b busy=%b level=%0d cmd_ready=%b want 0 0 0 1",
                 err, busy, fifo_level, cmd_ready);
      else passed++;
      model_q.delete();
    end
  endtask

  task automatic test_reset();
    bit bad;
    cmd_valid = 1'b0; cmd_dev_addr = 7'd0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = 8'd0; byte_done = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (pre_ready !== 1'b0 || pre_data !== 8'hFF || done !== 1'b0 || err !== 1'b0 ||
        busy !== 1'b0 || fifo_level !== LVL_W'(0) || wr_ready !== 1'b1)
      $display("FAIL reset_values: pre_ready=%b pre_data=%h done=%b err=%b busy=%b level=%0d want 0 ff 0 0 0 0",
               pre_ready, pre_data, done, err, busy, fifo_level);
    else passed++;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) byte_done = 1'b0;
      @(negedge clk);
      if (pre_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad || cmd_ready !== 1'b1) $display("FAIL reset_release: spurious output, cmd_ready=%b want 1", cmd_ready);
    else passed++;
    model_q.delete();
  endtask

  task automatic test_basic();
    apply_reset();
    push_byte(8'hAB);
    push_byte(8'hCD);
    run_txn(7'h50, 2, 20);
  endtask

  task automatic test_addr_only();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    run_txn(7'h3C, 0, -1);
  endtask

  task automatic test_underrun();
    apply_reset();
    push_byte(8'($urandom));
    run_txn(7'($urandom), 3, 5);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 17; i++) push_byte(8'($urandom));
    total++;
    if (fifo_level !== LVL_W'(16) || wr_ready !== 1'b0)
      $display("FAIL full: level=%0d wr_ready=%b want 16 0", fifo_level, wr_ready);
    else passed++;
  endtask

  task automatic test_push_pop();
    logic [6:0] a;
    logic [7:0] first, nb;
    apply_reset();
    for (int i = 0; i < 15; i++) push_byte(8'($urandom));
    a = 7'($urandom);
    first = model_q.pop_front();
    issue_cmd(a, 1);
    @(negedge clk);
    total++;
    if (pre_ready !== 1'b1 || pre_data !== {a, 1'b0})
      $display("FAIL pp_addr: pre_ready=%b pre_data=%h want 1 %h", pre_ready, pre_data, {a, 1'b0});
    else passed++;
    repeat (3) @(negedge clk);
    byte_done = 1'b1;
    @(negedge clk);
    byte_done = 1'b0;
    nb = 8'($urandom);
    wr_valid = 1'b1; wr_data = nb;
    @(negedge clk);
    wr_valid = 1'b0;
    model_q.push_back(nb);
    total++;
    if (pre_ready !== 1'b1 || pre_data !== first || fifo_level !== LVL_W'(15))
      $display("FAIL push_pop: pre_ready=%b pre_data=%h level=%0d want 1 %h 15", pre_ready, pre_data, fifo_level, first);
    else passed++;
    repeat (3) @(negedge clk);
    byte_done = 1'b1;
    @(negedge clk);
    byte_done = 1'b0;
    total++;
    if (done !== 1'b1) $display("FAIL pp_done: got %b want 1", done);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int n, len;
    apply_reset();
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(6, 0));
      for (int i = 0; i < n; i++) push_byte(8'($urandom));
      len = int'($urandom_range(model_q.size(), 0));
      run_txn(7'($urandom), len, -1);
    end
  endtask

  task automatic test_timeout_and_reset();
    logic [6:0] a;
    int at;
    apply_reset();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    a = 7'($urandom);
    issue_cmd(a, 2);
    @(negedge clk);
    total++;
    if (pre_ready !== 1'b1 || pre_data !== {a, 1'b0})
      $display("FAIL to_addr: pre_ready=%b pre_data=%h want 1 %h", pre_ready, pre_data, {a, 1'b0});
    else passed++;
    at = 0;
    for (int k = 1; k <= int'(TO) + 8; k++) begin
      @(negedge clk);
      if (err === 1'b1) begin at = k; break; end
    end
    total++;
    if (at != int'(TO)) $display("FAIL wait_timeout: err after %0d cycles want %0d", at, TO);
    else passed++;
    @(negedge clk);
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || fifo_level !== LVL_W'(0))
      $display("FAIL timeout_flush: err=%b busy=%b level=%0d want 0 0 0", err, busy, fifo_level);
    else passed++;
    model_q.delete();

    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    issue_cmd(7'($urandom), 3);
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL mid_wait_busy: got %b want 1", busy);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pre_ready !== 1'b0 || pre_data !== 8'hFF || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || fifo_level !== LVL_W'(0) || cmd_ready !== 1'b1)
      $display("FAIL async_reset: pre_ready=%b pre_data=%h busy=%b done=%b err=%b level=%0d cmd_ready=%b want 0 ff 0 0 0 0 1",
               pre_ready, pre_data, busy, done, err, fifo_level, cmd_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_only();
    test_underrun();
    test_full();
    test_push_pop();
    test_random();
    test_timeout_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_wr_seq.md
Name: i2c_wr_seq

Overview:
- Write-transaction sequencer directly upstream of the I2C byte sender; shares the sender's clk (2x I2C clock).
- Accepts a write command (7-bit device address plus byte count) and buffers payload bytes in an internal FIFO.
- Presents bytes to the sender one at a time: pre_ready pulse with pre_data held stable, then waits for the sender's byte_done before issuing the next byte.
- Reports completion, or timeout error, to the host side.

Parameters:
FIFO_DEPTH, 16, payload FIFO entries (power of 2, >=2)
LEN_W, 5, width of cmd_len; max payload 2^LEN_W-1 bytes
TIMEOUT, 1023, clk cycles allowed per byte before err

Ports:
clk  in  1  sender clock (2x I2C), all logic posedge
rst_n  in  1  async active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_dev_addr  in  7  target device address
cmd_len  in  LEN_W  payload byte count (0 = address-only)
wr_valid  in  1  payload byte valid
wr_ready  out  1  = FIFO not full
wr_data  in  8  payload byte
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
pre_ready  out  1  one-cycle byte-start pulse to sender
pre_data  out  8  byte to sender, held until byte_done rise
byte_done  in  1  sender level, high during ACK phase
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse, transaction complete
err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
- Reset values: state=IDLE, pre_ready=0, pre_data=8'hFF, done=0, err=0, busy=0, FIFO empty, fifo_level=0.
- byte_done edge detect: byte_done_q is a register that resets to 1, so a byte_done held high out of reset never yields a false edge. bd_rise = byte_done & ~byte_done_q.
- FIFO: push when wr_valid & wr_ready; wr_ready=0 when full, so pushes at full are dropped. Pop happens only in FETCH when non-empty.
  - Simultaneous push and pop: level unchanged; both pointers wrap modulo FIFO_DEPTH.
  - The FIFO accepts writes in every state, including IDLE.
- States:
  - IDLE:
    - cmd_ready=1. On cmd_valid: latch addr and rem=cmd_len, then go to ADDR.
  - ADDR (1 cycle):
    - pre_data <= {addr,1'b0}, pre_ready=1.
    - Clear timer, then go to WAIT.
  - WAIT:
    - pre_data held; timer++.
    - On bd_rise: go to DONE if rem==0, else to FETCH.
    - When timer==TIMEOUT-1 without bd_rise: go to ERR.
    - bd_rise on the timeout cycle wins.
  - FETCH:
    - Timer is cleared on entry.
    - If FIFO non-empty: pop, pre_data <= head, pre_ready=1 for that cycle, rem--, go to WAIT.
    - If empty: timer++; on TIMEOUT go to ERR (underrun).
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 for one cycle, flush FIFO (pointers/level to 0), then IDLE.
- Latency: cmd accept to first pre_ready = 1 cycle (ADDR). bd_rise to next pre_ready = 1 cycle if FIFO non-empty.
- pre_ready is never asserted in the same cycle as done or err.
- Bytes beyond cmd_len stay in the FIFO for the next command.
- cmd_len=0: a single address byte, then DONE.
- rem counts down with no wrap; FETCH is never entered with rem==0.
- Reset mid-transaction: immediate return to reset values; FIFO contents lost.

Test Plan:
- Reset with byte_done=1 held, release, drop byte_done -> no pre_ready, done, or err; cmd_ready=1.
- Prefill FIFO AB,CD; cmd addr=0x50, len=2; pulse byte_done 20 cycles after each pre_ready -> pre_data sequence A0, AB, CD, each stable until its bd_rise; 3 pre_ready pulses; done pulse 1 cycle after third bd_rise; FIFO empty.
- cmd addr=0x3C, len=0 -> one pre_ready with pre_data=0x78; done after bd_rise; FIFO untouched.
- len=3 with FIFO holding 1 byte and no further writes -> after second bd_rise, FETCH waits TIMEOUT cycles, err pulse, FIFO level 0, back to IDLE.
- Write 17 bytes with FIFO_DEPTH=16 -> wr_ready low after 16, 17th dropped, fifo_level=16; pop during push at full-1 keeps level constant.
- byte_done never rises after ADDR -> err exactly TIMEOUT cycles after pre_ready; rst_n asserted mid-WAIT -> all outputs return to reset values asynchronously.
